inst_issue_queue: RTL and testbench

//  Dual-issue instruction queue between the IF stage and the ID stage.
//  - Accepts up to two fetched instructions per cycle, each tagged with its PC and 2-bit fetch-exception code.
//  - Presents the two oldest entries to decode in show-ahead form; decode consumes 0, 1 or 2 per cycle.
//  - Decouples fetch from decode stalls.
//  - Flushes on redirect: interrupt, exception or taken branch.

---
 rtl/inst_issue_queue.sv | 122 ++++++++++++
 tb/tb_inst_issue_queue.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/inst_issue_queue.sv
// Dual-issue show-ahead instruction queue between fetch and decode.
// Pushes up to two entries per cycle, and up to two entries pop per cycle; a redirect flushes the queue.

module inst_issue_queue_lane (
  input  logic        vld,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [1:0]  exc,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [1:0]  out_exc
);
  // Invalid lanes present zeros so decode never sees stale storage.
  assign out_inst = vld ? inst : '0;
  assign out_pc   = vld ? pc   : '0;
  assign out_exc  = vld ? exc  : '0;
endmodule

module inst_issue_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [1:0]  in_valid,
  input  logic [31:0] in_inst0,
  input  logic [31:0] in_inst1,
  input  logic [31:0] in_pc,
  input  logic [1:0]  in_exc,
  output logic        in_ready,
  output logic [1:0]  out_valid,
  output logic [31:0] out_inst0,
  output logic [31:0] out_pc0,
  output logic [1:0]  out_exc0,
  output logic [31:0] out_inst1,
  output logic [31:0] out_pc1,
  output logic [1:0]  out_exc1,
  input  logic [1:0]  out_pop
);
  localparam int NUM_LANES = 2;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [1:0]  exc;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic [1:0]    push_n, pop_n, avail, req;

  entry_t [NUM_LANES-1:0]       hd;
  logic   [NUM_LANES-1:0][31:0] l_inst, l_pc;
  logic   [NUM_LANES-1:0][1:0]  l_exc;

  assign hd[0] = mem[head];
  assign hd[1] = mem[head + AW'(1)];

  assign in_ready     = count <= (AW+1)'(DEPTH - 2);
  assign out_valid[0] = count != '0;
  // An excepting head always issues alone.
  assign out_valid[1] = (count >= (AW+1)'(2)) && (hd[0].exc == 2'b00);

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      inst_issue_queue_lane u_lane (
        .vld      (out_valid[g]),
        .inst     (hd[g].inst),
        .pc       (hd[g].pc),
        .exc      (hd[g].exc),
        .out_inst (l_inst[g]),
        .out_pc   (l_pc[g]),
        .out_exc  (l_exc[g])
      );
    end
  endgenerate

  assign out_inst0 = l_inst[0];
  assign out_pc0   = l_pc[0];
  assign out_exc0  = l_exc[0];
  assign out_inst1 = l_inst[1];
  assign out_pc1   = l_pc[1];
  assign out_exc1  = l_exc[1];

  always_comb begin
    push_n = 2'd0;
    if (in_ready) begin
      if (in_valid == 2'b11)      push_n = 2'd2;
      else if (in_valid == 2'b01) push_n = 2'd1;
    end
    avail = out_valid[1] ? 2'd2 : (out_valid[0] ? 2'd1 : 2'd0);
    req   = (out_pop == 2'd3) ? 2'd2 : out_pop;
    pop_n = (req < avail) ? req : avail;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(pop_n);
      tail  <= tail + AW'(push_n);
      count <= count + (AW+1)'(push_n) - (AW+1)'(pop_n);
    end
  end

  // Storage is not reset; slot1 is never tagged with the fetch exception.
  always_ff @(posedge clk) begin
    if (!flush && push_n != 2'd0)
      mem[tail] <= '{inst: in_inst0, pc: in_pc, exc: in_exc};
    if (!flush && push_n == 2'd2)
      mem[tail + AW'(1)] <= '{inst: in_inst1, pc: in_pc + 32'd4, exc: 2'b00};
  end
endmodule

// File: tb/tb_inst_issue_queue.sv
// Scoreboard bench for inst_issue_queue: a queue-based reference model predicts
// each cycle's outputs; a negedge monitor compares them against the DUT.
module tb_inst_issue_queue;
  logic        clk = 1'b0;
  logic        reset, flush;
  logic [1:0]  in_valid, out_pop, in_exc;
  logic [31:0] in_inst0, in_inst1, in_pc;
  logic        in_ready;
  logic [1:0]  out_valid, out_exc0, out_exc1;
  logic [31:0] out_inst0, out_pc0, out_inst1, out_pc1;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [1:0]  exc;
  } ent_t;

  typedef struct packed {
    logic [1:0]  v;
    logic        rdy;
    logic [31:0] i0, p0;
    logic [1:0]  e0;
    logic [31:0] i1, p1;
    logic [1:0]  e1;
  } exp_t;

  ent_t mq[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  inst_issue_queue #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_inst0(in_inst0), .in_inst1(in_inst1), .in_pc(in_pc), .in_exc(in_exc),
    .in_ready(in_ready), .out_valid(out_valid),
    .out_inst0(out_inst0), .out_pc0(out_pc0), .out_exc0(out_exc0),
    .out_inst1(out_inst1), .out_pc1(out_pc1), .out_exc1(out_exc1),
    .out_pop(out_pop)
  );

  // Drive one cycle of inputs, predict this cycle's outputs, then advance the model past the edge.
  task automatic step(input logic rst, input logic fl, input logic [1:0] iv,
                      input logic [1:0] pop, input logic [31:0] pc, input logic [1:0] exc);
    exp_t e;
    int avail, req, pn;
    reset = rst; flush = fl; in_valid = iv; out_pop = pop;
    in_pc = pc; in_exc = exc; in_inst0 = $urandom; in_inst1 = $urandom;
    if (rst) mq.delete();
    e = '0;
    e.rdy = (8 - mq.size()) >= 2;
    if (mq.size() >= 1) begin
      e.v[0] = 1'b1; e.i0 = mq[0].inst; e.p0 = mq[0].pc; e.e0 = mq[0].exc;
    end
    if (mq.size() >= 2 && mq[0].exc == 2'b00) begin
      e.v[1] = 1'b1; e.i1 = mq[1].inst; e.p1 = mq[1].pc; e.e1 = mq[1].exc;
    end
    sb.push_back(e);
    if (!rst) begin
      if (fl) mq.delete();
      else begin
        avail = e.v[1] ? 2 : (e.v[0] ? 1 : 0);
        req   = (pop == 2'd3) ? 2 : int'(pop);
        pn    = (req < avail) ? req : avail;
        repeat (pn) void'(mq.pop_front());
        if (e.rdy && iv[0]) begin
          mq.push_back('{inst: in_inst0, pc: pc, exc: exc});
          if (iv[1]) mq.push_back('{inst: in_inst1, pc: pc + 32'd4, exc: 2'b00});
        end
      end
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (out_valid !== e.v || in_ready !== e.rdy) begin
        failures++;
        $display("FAIL valid_ready t=%0t got v=%b rdy=%b exp v=%b rdy=%b",
                 $time, out_valid, in_ready, e.v, e.rdy);
      end
      checks++;
      if (out_inst0 !== e.i0 || out_pc0 !== e.p0 || out_exc0 !== e.e0) begin
        failures++;
        $display("FAIL lane0 t=%0t got %h/%h/%b exp %h/%h/%b",
                 $time, out_inst0, out_pc0, out_exc0, e.i0, e.p0, e.e0);
      end
      checks++;
      if (out_inst1 !== e.i1 || out_pc1 !== e.p1 || out_exc1 !== e.e1) begin
        failures++;
        $display("FAIL lane1 t=%0t got %h/%h/%b exp %h/%h/%b",
                 $time, out_inst1, out_pc1, out_exc1, e.i1, e.p1, e.e1);
      end
    end
  end

  initial begin
    logic        r, f;
    logic [1:0]  iv, pop, ex;
    logic [31:0] pc;
    bit          fill;
    reset = 1'b1; flush = 1'b0; in_valid = '0; out_pop = '0;
    in_pc = '0; in_exc = '0; in_inst0 = '0; in_inst1 = '0;
    @(posedge clk); #1;
    step(1, 0, 2'b00, 0, 0, 0);
    // reach count=5, then reset mid-run and push 0x100 pair
    step(0, 0, 2'b11, 0, 32'h40, 0);
    step(0, 0, 2'b11, 0, 32'h48, 0);
    step(0, 0, 2'b01, 0, 32'h50, 0);
    step(1, 0, 2'b11, 1, 32'h60, 0);
    step(0, 0, 2'b11, 0, 32'h100, 0);
    step(0, 0, 2'b00, 0, 0, 0);
    // fill to 8, fifth pair dropped, then drain to head=6 and push across the wrap
    step(1, 0, 2'b00, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 2'b11, 0, 32'h1000 + 32'(8 * k), 0);
    step(0, 0, 2'b00, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 2'b00, 2, 0, 0);
    step(0, 0, 2'b11, 0, 32'h200, 0);
    step(0, 0, 2'b00, 2, 0, 0);
    step(0, 0, 2'b00, 2, 0, 0);
    step(0, 0, 2'b00, 0, 0, 0);
    // excepting head issues alone
    step(0, 0, 2'b11, 0, 32'h300, 2'b10);
    step(0, 0, 2'b01, 0, 32'h308, 0);
    step(0, 0, 2'b00, 2, 0, 0);
    step(0, 0, 2'b00, 2, 0, 0);
    // count=1 with pop of 2
    step(0, 0, 2'b01, 0, 32'h400, 0);
    step(0, 0, 2'b00, 2, 0, 0);
    step(0, 0, 2'b00, 3, 0, 0);
    // flush with simultaneous push and pop
    step(0, 0, 2'b11, 0, 32'h500, 0);
    step(0, 1, 2'b11, 1, 32'h508, 0);
    step(0, 0, 2'b10, 0, 32'h510, 0);
    step(0, 0, 2'b00, 0, 0, 0);
    // randomized phases alternating between filling and draining
    for (int blk = 0; blk < 20; blk++) begin
      fill = blk[0];
      for (int c = 0; c < 200; c++) begin
        r   = ($urandom % 400) == 0;
        f   = ($urandom % 40) == 0;
        iv  = 2'($urandom);
        pop = fill ? 2'($urandom % 2) : 2'($urandom);
        pc  = $urandom & 32'hFFFF_FFFC;
        ex  = (($urandom % 4) == 0) ? 2'($urandom) : 2'b00;
        step(r, f, iv, pop, pc, ex);
      end
    end
    step(0, 0, 2'b00, 0, 0, 0);
    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
